vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- c_pxl_visible, 640, visible columns
- c_pxl_fporch, 16, horizontal front porch in pixels
- c_pxl_synch, 96, hsync width in pixels
- c_pxl_total, 800, total pixels per line
- c_line_visible, 480, visible lines
- c_line_fporch, 9, vertical front porch in lines
- c_line_synch, 2, vsync width in lines
- c_line_total, 520, total lines per frame
- c_nb_pxls, 10, column counter width
- c_nb_lines, 10, line counter width
- c_clk_div, 4, clk cycles per pixel, legal values >=1
- c_hsync_act, 0, hsync active level
- c_vsync_act, 0, vsync active level
- c_scale_log2, 1, coordinate downscale shift (1 gives 320x240 from 640x480)
- c_nb_frame, 8, frame counter width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, reset
- en, in, 1, timing advance enable; low freezes the generator
- new_pxl, out, 1, one-clk pulse on the last clk of each pixel period
- visible, out, 1, current pixel is in the active area
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- col, out, c_nb_pxls, current column
- row, out, c_nb_lines, current line
- col_sc, out, c_nb_pxls, col >> c_scale_log2
- row_sc, out, c_nb_lines, row >> c_scale_log2
- line_start, out, 1, pulse coincident with new_pxl when col==0
- frame_start, out, 1, pulse coincident with new_pxl when col==0 and row==0
- frame_cnt, out, c_nb_frame, completed-frame count
REQ-003 One clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 The divider SHALL count 0..c_clk_div-1 on clk and advance only while en=1. Internal tick = en && div==c_clk_div-1. If c_clk_div==1, tick = en.
REQ-005 The pixel counter SHALL advance on tick and wrap from c_pxl_total-1 to 0. The line counter SHALL advance on tick at pixel c_pxl_total-1 and wrap from c_line_total-1 to 0.
REQ-006 Horizontal decode from the pixel counter p:
- p < c_pxl_visible: visible_h
- c_pxl_visible+c_pxl_fporch <= p < c_pxl_visible+c_pxl_fporch+c_pxl_synch: hsync active
- otherwise: hsync inactive
Vertical decode from the line counter uses the c_line_* parameters in the same way.
REQ-007 Every output SHALL be registered, one clk after the internal counter/tick state it reflects. Timing per output:
- new_pxl = registered tick
- col and row hold for the whole pixel period
- visible = visible_h && visible_v
REQ-008 col_sc and row_sc SHALL be a logical right shift of the registered col/row, with identical timing.
REQ-009 line_start SHALL be the registered value of (tick && p==0). frame_start SHALL be the registered value of (tick && p==0 && line==0).
REQ-010 frame_cnt SHALL increment, wrapping modulo 2^c_nb_frame, on the tick where p==c_pxl_total-1 and line==c_line_total-1.
REQ-011 While en=0:
- divider, counters and frame_cnt hold
- new_pxl, line_start and frame_start are 0
- hsync, vsync, visible, col and row keep their last values
When en returns to 1, counting resumes from the held divider value with no skipped or repeated pixel.
REQ-012 Frame period at en=1 SHALL be c_clk_div*c_pxl_total*c_line_total clks exactly.

Reset
REQ-013 On rst=1 at a clk edge:
- divider, pixel counter, line counter, frame_cnt, col, row, col_sc and row_sc are set to 0
- visible, new_pxl, line_start and frame_start are set to 0
- hsync is set to ~c_hsync_act and vsync to ~c_vsync_act
REQ-014 rst SHALL take priority over en. A mid-frame reset SHALL restart timing at pixel 0, line 0, with the first tick c_clk_div clks after rst deasserts.

Verification
REQ-015 Reset: hold rst 3 clks mid-frame -> all outputs at the REQ-013 values. First new_pxl comes 4 clks after release; its frame_start=1, col=0, row=0.
REQ-016 Defaults, en=1: new_pxl every 4 clks. hsync low for exactly 384 clks starting at col 656. Line period 3200 clks. vsync low for 2 lines starting at row 489.
REQ-017 Frame: two frames -> frame_start spacing 1,664,000 clks. frame_cnt increments at each line-519/col-799 tick, and 255 wraps to 0.
REQ-018 Scaling: at col=639, row=479 -> col_sc=319, row_sc=239 and visible=1. At col=640 -> visible=0.
REQ-019 Freeze: en=0 for 17 clks mid-line -> no pulses, col/row/hsync constant. After release, the next col value is previous col+1.
REQ-020 c_clk_div=1 and c_hsync_act=1 build -> new_pxl high every clk with en=1. hsync high for cols 656-751. Frame period 416,000 clks.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA-style raster timing generator.
//
// A clock divider produces one pixel tick every c_clk_div clocks. Pixel and line counters
// advance on that tick, and the horizontal and vertical timing is decoded from them. Every
// output is registered. The coordinate and sync outputs change only on a tick, so they stay
// stable for the whole pixel period and hold their values while en is low.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset; takes priority over en
//   en           timing advance enable; low freezes the generator
//   new_pxl      one-clk pulse on the last clk of each pixel period
//   visible      current pixel is inside the active area
//   hsync/vsync  sync outputs; c_hsync_act/c_vsync_act set the active level
//   col/row      current column and line
//   col_sc/row_sc  col and row shifted right by c_scale_log2
//   line_start   pulse coincident with new_pxl when col == 0
//   frame_start  pulse coincident with new_pxl when col == 0 and row == 0
//   frame_cnt    completed-frame count, wraps modulo 2^c_nb_frame
module vga_sync_gen #(
  parameter int unsigned c_pxl_visible  = 640,
  parameter int unsigned c_pxl_fporch   = 16,
  parameter int unsigned c_pxl_synch    = 96,
  parameter int unsigned c_pxl_total    = 800,
  parameter int unsigned c_line_visible = 480,
  parameter int unsigned c_line_fporch  = 9,
  parameter int unsigned c_line_synch   = 2,
  parameter int unsigned c_line_total   = 520,
  parameter int unsigned c_nb_pxls      = 10,
  parameter int unsigned c_nb_lines     = 10,
  parameter int unsigned c_clk_div      = 4,
  parameter int unsigned c_hsync_act    = 0,
  parameter int unsigned c_vsync_act    = 0,
  parameter int unsigned c_scale_log2   = 1,
  parameter int unsigned c_nb_frame     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  new_pxl,
  output logic                  visible,
  output logic                  hsync,
  output logic                  vsync,
  output logic [c_nb_pxls-1:0]  col,
  output logic [c_nb_lines-1:0] row,
  output logic [c_nb_pxls-1:0]  col_sc,
  output logic [c_nb_lines-1:0] row_sc,
  output logic                  line_start,
  output logic                  frame_start,
  output logic [c_nb_frame-1:0] frame_cnt
);

  // The divider keeps at least one bit so that c_clk_div == 1 still builds. In that case the
  // divider stays at 0, which always equals the last count, so tick follows en directly.
  localparam int unsigned div_w = (c_clk_div > 1) ? $clog2(c_clk_div) : 1;
  localparam logic [div_w-1:0] div_last = div_w'(c_clk_div - 1);

  localparam logic [c_nb_pxls-1:0] pxl_last = c_nb_pxls'(c_pxl_total - 1);
  localparam logic [c_nb_pxls-1:0] pxl_vis  = c_nb_pxls'(c_pxl_visible);
  localparam logic [c_nb_pxls-1:0] hs_beg   = c_nb_pxls'(c_pxl_visible + c_pxl_fporch);
  localparam logic [c_nb_pxls-1:0] hs_end   =
      c_nb_pxls'(c_pxl_visible + c_pxl_fporch + c_pxl_synch);

  localparam logic [c_nb_lines-1:0] line_last = c_nb_lines'(c_line_total - 1);
  localparam logic [c_nb_lines-1:0] line_vis  = c_nb_lines'(c_line_visible);
  localparam logic [c_nb_lines-1:0] vs_beg    = c_nb_lines'(c_line_visible + c_line_fporch);
  localparam logic [c_nb_lines-1:0] vs_end    =
      c_nb_lines'(c_line_visible + c_line_fporch + c_line_synch);

  localparam logic hs_on = (c_hsync_act != 0);
  localparam logic vs_on = (c_vsync_act != 0);

  logic [div_w-1:0]      div_cnt;
  logic [c_nb_pxls-1:0]  pxl_cnt;
  logic [c_nb_lines-1:0] line_cnt;

  logic tick;
  logic visible_h;
  logic visible_v;
  logic hsync_on;
  logic vsync_on;
  logic pxl_wrap;
  logic line_wrap;

  always_comb begin
    tick      = en && (div_cnt == div_last);
    visible_h = (pxl_cnt < pxl_vis);
    visible_v = (line_cnt < line_vis);
    hsync_on  = (pxl_cnt >= hs_beg) && (pxl_cnt < hs_end);
    vsync_on  = (line_cnt >= vs_beg) && (line_cnt < vs_end);
    pxl_wrap  = (pxl_cnt == pxl_last);
    line_wrap = (line_cnt == line_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      pxl_cnt     <= '0;
      line_cnt    <= '0;
      frame_cnt   <= '0;
      new_pxl     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      visible     <= 1'b0;
      hsync       <= ~hs_on;
      vsync       <= ~vs_on;
      col         <= '0;
      row         <= '0;
      col_sc      <= '0;
      row_sc      <= '0;
    end else begin
      // Pulses are the registered tick, so they are forced low while en is low.
      new_pxl     <= tick;
      line_start  <= tick && (pxl_cnt == '0);
      frame_start <= tick && (pxl_cnt == '0) && (line_cnt == '0);

      if (en) begin
        div_cnt <= (div_cnt == div_last) ? '0 : div_cnt + 1'b1;
      end

      if (tick) begin
        // Capture the pixel being presented before the counters move on to the next one.
        col     <= pxl_cnt;
        row     <= line_cnt;
        col_sc  <= pxl_cnt >> c_scale_log2;
        row_sc  <= line_cnt >> c_scale_log2;
        visible <= visible_h && visible_v;
        hsync   <= hsync_on ? hs_on : ~hs_on;
        vsync   <= vsync_on ? vs_on : ~vs_on;

        if (pxl_wrap) begin
          pxl_cnt <= '0;
          if (line_wrap) begin
            line_cnt  <= '0;
            frame_cnt <= frame_cnt + 1'b1;
          end else begin
            line_cnt <= line_cnt + 1'b1;
          end
        end else begin
          pxl_cnt <= pxl_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a reduced raster so that several frames fit in a short run.
// Instance u_dut uses c_clk_div = 3 with active-low syncs and random en. A reference model
// maps the count of enabled clocks since reset onto a pixel index with plain arithmetic, and
// pushes the expected pixel record on each tick. A monitor pops that record when the DUT
// raises new_pxl. Between pulses, the monitor checks that the outputs hold their values.
// Instance u_dut2 uses c_clk_div = 1 with active-high syncs and en tied high.
module tb_vga_sync_gen;

  localparam int unsigned PV = 10, PF = 2, PS = 3, PT = 20;
  localparam int unsigned LV = 6, LF = 1, LS = 2, LT = 12;
  localparam int unsigned D = 3, SCALE = 1, NBF = 3;

  typedef struct packed {
    logic [9:0]     col;
    logic [9:0]     row;
    logic [9:0]     col_sc;
    logic [9:0]     row_sc;
    logic           vis;
    logic           hs;
    logic           vs;
    logic           ls;
    logic           fs;
    logic [NBF-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic           new_pxl, visible, hsync, vsync, line_start, frame_start;
  logic [9:0]     col, row, col_sc, row_sc;
  logic [NBF-1:0] frame_cnt;

  logic           new_pxl2, visible2, hsync2, vsync2, line_start2, frame_start2;
  logic [9:0]     col2, row2, col_sc2, row_sc2;
  logic [NBF-1:0] frame_cnt2;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t hold;
  logic last_rst = 1'b1;
  logic done     = 1'b0;
  int unsigned ecnt = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .c_pxl_visible(PV), .c_pxl_fporch(PF), .c_pxl_synch(PS), .c_pxl_total(PT),
    .c_line_visible(LV), .c_line_fporch(LF), .c_line_synch(LS), .c_line_total(LT),
    .c_nb_pxls(10), .c_nb_lines(10), .c_clk_div(D), .c_hsync_act(0), .c_vsync_act(0),
    .c_scale_log2(SCALE), .c_nb_frame(NBF)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .new_pxl(new_pxl), .visible(visible), .hsync(hsync),
    .vsync(vsync), .col(col), .row(row), .col_sc(col_sc), .row_sc(row_sc),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  vga_sync_gen #(
    .c_pxl_visible(PV), .c_pxl_fporch(PF), .c_pxl_synch(PS), .c_pxl_total(PT),
    .c_line_visible(LV), .c_line_fporch(LF), .c_line_synch(LS), .c_line_total(LT),
    .c_nb_pxls(10), .c_nb_lines(10), .c_clk_div(1), .c_hsync_act(1), .c_vsync_act(1),
    .c_scale_log2(SCALE), .c_nb_frame(NBF)
  ) u_dut2 (
    .clk(clk), .rst(rst), .en(1'b1), .new_pxl(new_pxl2), .visible(visible2),
    .hsync(hsync2), .vsync(vsync2), .col(col2), .row(row2), .col_sc(col_sc2),
    .row_sc(row_sc2), .line_start(line_start2), .frame_start(frame_start2),
    .frame_cnt(frame_cnt2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected record for the idx-th pixel tick since reset.
  function automatic exp_t model(input int unsigned idx);
    exp_t e;
    int unsigned p, l;
    p        = idx % PT;
    l        = (idx / PT) % LT;
    e.col    = 10'(p);
    e.row    = 10'(l);
    e.col_sc = 10'(p >> SCALE);
    e.row_sc = 10'(l >> SCALE);
    e.vis    = (p < PV) && (l < LV);
    e.hs     = (p >= PV + PF && p < PV + PF + PS) ? 1'b0 : 1'b1;
    e.vs     = (l >= LV + LF && l < LV + LF + LS) ? 1'b0 : 1'b1;
    e.ls     = (p == 0);
    e.fs     = (p == 0) && (l == 0);
    e.fc     = NBF'((idx + 1) / (PT * LT));
    return e;
  endfunction

  function automatic exp_t reset_rec();
    exp_t e;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  // Drive one clock; the model then accounts for the values the DUT sampled at that edge.
  task automatic step(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge clk);
    last_rst = r;
    if (r) begin
      ecnt = 0;
    end else if (e) begin
      ecnt++;
      if (ecnt % D == 0) exp_q.push_back(model(ecnt / D - 1));
    end
    #1;
  endtask

  // Monitor for u_dut.
  always @(negedge clk) begin
    if (!done) begin
      if (last_rst) begin
        hold = reset_rec();
        check("rst_new_pxl", int'(new_pxl), 0);
        check("rst_col", int'(col), 0);
        check("rst_row", int'(row), 0);
        check("rst_col_sc", int'(col_sc), 0);
        check("rst_row_sc", int'(row_sc), 0);
        check("rst_visible", int'(visible), 0);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_line_start", int'(line_start), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
      end else if (new_pxl) begin
        if (exp_q.size() == 0) begin
          check("unexpected_new_pxl", 1, 0);
        end else begin
          hold = exp_q.pop_front();
          check("col", int'(col), int'(hold.col));
          check("row", int'(row), int'(hold.row));
          check("col_sc", int'(col_sc), int'(hold.col_sc));
          check("row_sc", int'(row_sc), int'(hold.row_sc));
          check("visible", int'(visible), int'(hold.vis));
          check("hsync", int'(hsync), int'(hold.hs));
          check("vsync", int'(vsync), int'(hold.vs));
          check("line_start", int'(line_start), int'(hold.ls));
          check("frame_start", int'(frame_start), int'(hold.fs));
          check("frame_cnt", int'(frame_cnt), int'(hold.fc));
        end
      end else begin
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          check("missing_new_pxl", 0, 1);
        end
        check("hold_col", int'(col), int'(hold.col));
        check("hold_row", int'(row), int'(hold.row));
        check("hold_hsync", int'(hsync), int'(hold.hs));
        check("hold_vsync", int'(vsync), int'(hold.vs));
        check("hold_visible", int'(visible), int'(hold.vis));
        check("hold_frame_cnt", int'(frame_cnt), int'(hold.fc));
        check("idle_line_start", int'(line_start), 0);
        check("idle_frame_start", int'(frame_start), 0);
      end
    end
  end

  // Checker for u_dut2: one pixel per clk, active-high syncs, frame period PT*LT clks.
  int c2_since   = 0;
  int c2_last_fs = -1;
  always @(negedge clk) begin
    if (!done) begin
      if (last_rst) begin
        c2_since   = 0;
        c2_last_fs = -1;
        check("dut2_rst_hsync", int'(hsync2), 0);
      end else begin
        c2_since++;
        check("dut2_new_pxl", int'(new_pxl2), 1);
        check("dut2_hsync", int'(hsync2), int'(col2 >= PV + PF && col2 < PV + PF + PS));
        check("dut2_vsync", int'(vsync2), int'(row2 >= LV + LF && row2 < LV + LF + LS));
        if (frame_start2) begin
          if (c2_last_fs >= 0) check("dut2_frame_period", c2_since - c2_last_fs, PT * LT);
          c2_last_fs = c2_since;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1);
    // Freeze mid-line.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 8000; i++) step(1'b0, ($urandom_range(3, 0) != 0));
    // Mid-frame reset, with en high to confirm reset wins.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
